// File: rtl/cnt10_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cnt10_ctrl_pkg
// Description : Shared definitions for the cnt10 job controller: digit width,
//               largest legal decimal digit, FSM state type and a digit
//               range-check helper.
//               The PAUSE state exists only when CNT10_CTRL_PAUSE_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt10_ctrl_pkg;

  localparam int               DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // Explicit 3-bit encoding keeps state values stable across builds with
  // and without the pause feature.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
`ifdef CNT10_CTRL_PAUSE_EN
    ST_PAUSE = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnt10_ctrl_rounds.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cnt10_ctrl_rounds
// Description : Remaining-round register. Loads a new round count, otherwise
//               decrements on request and saturates at zero.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               load_i           - load load_val_i (priority over dec_i)
//               load_val_i       - round count captured at job start
//               dec_i            - one carry-out observed this cycle
//               rounds_left_o    - current remaining count
//               zero_o           - remaining count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module cnt10_ctrl_rounds #(
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [ROUND_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [ROUND_W-1:0] rounds_left_o,
  output logic               zero_o
);

  localparam logic [ROUND_W-1:0] C_ONE = {{(ROUND_W-1){1'b0}}, 1'b1};

  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] rounds_d;

  always_comb begin
    rounds_d = rounds_q;
    if (load_i) begin
      rounds_d = load_val_i;
    end else if (dec_i && (rounds_q != '0)) begin
      rounds_d = rounds_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_q <= '0;
    end else begin
      rounds_q <= rounds_d;
    end
  end

  assign rounds_left_o = rounds_q;
  assign zero_o        = (rounds_q == '0);

endmodule
`default_nettype wire

// File: rtl/cnt10_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cnt10_ctrl
// Description : Job controller for an external decimal counter (cnt10).
//               A job loads a preset digit, lets the counter pass a number
//               of carry-outs, then stops it on a chosen digit.
//               Optional feature macro: CNT10_CTRL_PAUSE_EN adds the pause
//               input and a PAUSE state that freezes counting.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               start, abort          - job request / cancel
//               preset, rounds, stop_q- job parameters (captured on start)
//               pause                 - hold counting (macro builds only)
//               cnt_q, cnt_cout       - counter value and carry-out
//               cnt_en, cnt_load,
//               cnt_d                 - counter controls
//               busy, done, err       - status (done/err are 1-cycle pulses)
//               rounds_left           - carry-outs still to pass
// Revision    : 1.0 - initial release
// ============================================================================
module cnt10_ctrl
  import cnt10_ctrl_pkg::*;
#(
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIGIT_W-1:0] preset,
  input  logic [ROUND_W-1:0] rounds,
  input  logic [DIGIT_W-1:0] stop_q,
`ifdef CNT10_CTRL_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [DIGIT_W-1:0] cnt_q,
  input  logic               cnt_cout,
  output logic               cnt_en,
  output logic               cnt_load,
  output logic [DIGIT_W-1:0] cnt_d,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ROUND_W-1:0] rounds_left
);

  state_e             state_q;
  state_e             state_d;
  logic [DIGIT_W-1:0] preset_dig_q;
  logic [DIGIT_W-1:0] stop_dig_q;
  logic               err_q;

  logic               start_ok;
  logic               accept;
  logic               reject;
  logic               rounds_zero;
  logic               at_stop;
  logic               dec;

  assign start_ok = digit_ok(preset) && digit_ok(stop_q);
  assign accept   = (state_q == ST_IDLE) && start && start_ok;
  assign reject   = (state_q == ST_IDLE) && start && !start_ok;
  assign at_stop  = rounds_zero && (cnt_q == stop_dig_q);

  // Counter controls are combinational so that abort and rst freeze the
  // counter in the very cycle they are seen, leaving its value untouched.
  always_comb begin
    state_d  = state_q;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (at_stop) begin
          state_d = ST_DONE;
`ifdef CNT10_CTRL_PAUSE_EN
        end else if (pause) begin
          state_d = ST_PAUSE;
`endif
        end else begin
          cnt_en = 1'b1;
          dec    = cnt_cout;
        end
      end
`ifdef CNT10_CTRL_PAUSE_EN
      ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
      dec      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      preset_dig_q <= '0;
      stop_dig_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        preset_dig_q <= preset;
        stop_dig_q   <= stop_q;
      end
    end
  end

  cnt10_ctrl_rounds #(
    .ROUND_W (ROUND_W)
  ) u_rounds (
    .clk           (clk),
    .rst           (rst),
    .load_i        (accept),
    .load_val_i    (rounds),
    .dec_i         (dec),
    .rounds_left_o (rounds_left),
    .zero_o        (rounds_zero)
  );

  assign cnt_d = preset_dig_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt10_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cnt10_ctrl
// Description : Self-checking bench for cnt10_ctrl with a cnt10 counter
//               placed beside it. Expected behaviour is computed from the
//               job rules with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt10_ctrl;

  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    preset;
  logic [RW-1:0] rounds;
  logic [3:0]    stop_q;
`ifdef CNT10_CTRL_PAUSE_EN
  logic          pause;
`endif
  logic [3:0]    cnt_q;
  logic          cnt_cout;
  logic          cnt_en;
  logic          cnt_load;
  logic [3:0]    cnt_d;
  logic          busy;
  logic          done;
  logic          err;
  logic [RW-1:0] rounds_left;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cnt10_ctrl #(
    .ROUND_W (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .preset      (preset),
    .rounds      (rounds),
    .stop_q      (stop_q),
`ifdef CNT10_CTRL_PAUSE_EN
    .pause       (pause),
`endif
    .cnt_q       (cnt_q),
    .cnt_cout    (cnt_cout),
    .cnt_en      (cnt_en),
    .cnt_load    (cnt_load),
    .cnt_d       (cnt_d),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rounds_left (rounds_left)
  );

  // The controlled decimal counter.
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
  end
  assign cnt_cout = cnt_en && (cnt_q == 4'd9);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Increments from preset p until the stop digit s is honoured after r
  // carry-outs: the first total count t = p + k with t/10 >= r and t%10 == s.
  function automatic int incs_needed(input int p, input int r, input int s);
    int t;
    t = 10 * r + s;
    if (t < p) t += 10;
    return t - p;
  endfunction

  function automatic int rl_after(input int p, input int r, input int j);
    int w;
    w = (p + j) / 10;
    return (r > w) ? r - w : 0;
  endfunction

  task automatic run_job(input int p, input int r, input int s, input bit noisy);
    int k;
    k = incs_needed(p, r, s);
    start  = 1'b1;
    preset = 4'(p);
    rounds = RW'(r);
    stop_q = 4'(s);
    step();
    start = 1'b0;
    if (noisy) begin
      preset = 4'($urandom_range(15, 0));
      stop_q = 4'($urandom_range(15, 0));
      rounds = RW'($urandom_range(255, 0));
    end
    settle();
    chk("load_busy",     32'(busy),        1);
    chk("load_cnt_load", 32'(cnt_load),    1);
    chk("load_cnt_en",   32'(cnt_en),      0);
    chk("load_cnt_d",    32'(cnt_d),       p);
    chk("load_rounds",   32'(rounds_left), r);
    step();
    for (int j = 0; j < k; j++) begin
      if (noisy) start = 1'($urandom_range(1, 0));
      settle();
      chk("run_cnt_q",  32'(cnt_q),       (p + j) % 10);
      chk("run_rounds", 32'(rounds_left), rl_after(p, r, j));
      chk("run_cnt_en", 32'(cnt_en),      1);
      chk("run_cnt_d",  32'(cnt_d),       p);
      chk("run_done",   32'(done),        0);
      chk("run_err",    32'(err),         0);
      step();
    end
    start = 1'b0;
    settle();
    chk("stop_cnt_q",  32'(cnt_q),       s);
    chk("stop_rounds", 32'(rounds_left), 0);
    chk("stop_cnt_en", 32'(cnt_en),      0);
    chk("stop_done",   32'(done),        0);
    step();
    chk("done_pulse",  32'(done),  1);
    chk("done_busy",   32'(busy),  1);
    chk("done_cnt_q",  32'(cnt_q), s);
    chk("done_cnt_en", 32'(cnt_en), 0);
    step();
    chk("idle_done",  32'(done),  0);
    chk("idle_busy",  32'(busy),  0);
    chk("idle_cnt_q", 32'(cnt_q), s);
  endtask

  task automatic bad_start(input int p, input int s);
    start  = 1'b1;
    preset = 4'(p);
    stop_q = 4'(s);
    rounds = RW'(1);
    step();
    start = 1'b0;
    settle();
    chk("err_pulse",    32'(err),      1);
    chk("err_busy",     32'(busy),     0);
    chk("err_cnt_load", 32'(cnt_load), 0);
    step();
    chk("err_clear",    32'(err),      0);
    chk("err_busy2",    32'(busy),     0);
    chk("err_cnt_load2",32'(cnt_load), 0);
  endtask

  initial begin
    int held;
    bit seen_done;
    cnt_q  = 4'd0;
    rst    = 1'b1;
    start  = 1'b1;
    abort  = 1'b1;
    preset = 4'd12;
    rounds = RW'(7);
    stop_q = 4'd3;
`ifdef CNT10_CTRL_PAUSE_EN
    pause  = 1'b0;
`endif

    // Reset overrides every other input.
    step();
    step();
    settle();
    chk("rst_busy",     32'(busy),        0);
    chk("rst_done",     32'(done),        0);
    chk("rst_err",      32'(err),         0);
    chk("rst_cnt_en",   32'(cnt_en),      0);
    chk("rst_cnt_load", 32'(cnt_load),    0);
    chk("rst_cnt_d",    32'(cnt_d),       0);
    chk("rst_rounds",   32'(rounds_left), 0);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step();

    // Directed jobs.
    run_job(5, 0, 8, 1'b0);
    run_job(7, 2, 3, 1'b0);
    run_job(4, 0, 4, 1'b0);
    run_job(9, 1, 0, 1'b0);

    // Abort in RUN at cnt_q = 4.
    start = 1'b1; preset = 4'd2; rounds = RW'(1); stop_q = 4'd9;
    step();
    start = 1'b0;
    step();
    step();
    step();
    settle();
    chk("abort_pre_q", 32'(cnt_q), 4);
    abort = 1'b1;
    start = 1'b1;
    settle();
    chk("abort_cnt_en_now", 32'(cnt_en), 0);
    step();
    abort = 1'b0;
    start = 1'b0;
    settle();
    chk("abort_busy",   32'(busy),        0);
    chk("abort_cnt_en", 32'(cnt_en),      0);
    chk("abort_done",   32'(done),        0);
    chk("abort_cnt_q",  32'(cnt_q),       4);
    chk("abort_rounds", 32'(rounds_left), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_hold_done", 32'(done),  0);
      chk("abort_hold_q",    32'(cnt_q), 4);
    end

    // Abort during LOAD suppresses the load.
    start = 1'b1; preset = 4'd8; rounds = RW'(0); stop_q = 4'd1;
    step();
    start = 1'b0;
    abort = 1'b1;
    settle();
    chk("abort_load_cnt_load", 32'(cnt_load), 0);
    step();
    abort = 1'b0;
    settle();
    chk("abort_load_busy", 32'(busy),  0);
    chk("abort_load_q",    32'(cnt_q), 4);

    // Rejected starts.
    bad_start(12, 3);
    bad_start(3, 10);

    // Reset in the middle of a job.
    start = 1'b1; preset = 4'd0; rounds = RW'(3); stop_q = 4'd5;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    settle();
    chk("rst_mid_cnt_en_now", 32'(cnt_en), 0);
    step();
    chk("rst_mid_busy",     32'(busy),        0);
    chk("rst_mid_done",     32'(done),        0);
    chk("rst_mid_err",      32'(err),         0);
    chk("rst_mid_cnt_en",   32'(cnt_en),      0);
    chk("rst_mid_cnt_load", 32'(cnt_load),    0);
    chk("rst_mid_cnt_d",    32'(cnt_d),       0);
    chk("rst_mid_rounds",   32'(rounds_left), 0);
    chk("rst_mid_cnt_q",    32'(cnt_q),       3);
    rst = 1'b0;
    run_job(1, 0, 2, 1'b0);

`ifdef CNT10_CTRL_PAUSE_EN
    // Pause for four cycles at cnt_q = 6.
    start = 1'b1; preset = 4'd3; rounds = RW'(1); stop_q = 4'd5;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    pause = 1'b1;
    settle();
    chk("pause_cnt_en_now", 32'(cnt_en), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause_q",      32'(cnt_q),       6);
      chk("pause_rounds", 32'(rounds_left), 1);
      chk("pause_busy",   32'(busy),        1);
    end
    pause = 1'b0;
    step();
    chk("resume_q0", 32'(cnt_q), 6);
    step();
    chk("resume_q1", 32'(cnt_q), 7);
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else step();
    end
    chk("pause_done_seen", 32'(seen_done), 1);
    chk("pause_done_q",    32'(cnt_q),     5);
    step();
`endif

    // Randomized jobs with scrambled inputs while busy.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        bad_start(10 + int'($urandom_range(5, 0)), int'($urandom_range(9, 0)));
      end
      run_job(int'($urandom_range(9, 0)), int'($urandom_range(2, 0)),
              int'($urandom_range(9, 0)), 1'b1);
    end

    held = int'(cnt_q);
    step();
    chk("final_hold_q", 32'(cnt_q), held);
    chk("final_busy",   32'(busy),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
